// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax engine TCDM splitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sfm_pkg;

   // Width of one TCDM lane and its byte-enable field.
   localparam int TCDM_LANE_W    = 32;
   localparam int TCDM_LANE_BE_W = TCDM_LANE_W / 8;

   // IDLE: no lane of the current wide request has been granted yet.
   // PARTIAL: some lanes granted, remaining lanes still being requested.
   typedef enum logic {SPLIT_IDLE, SPLIT_PARTIAL} sfm_split_state_e;

   // Byte address of lane idx for a word-aligned wide base address.
   // Wraps modulo 2^32 like the bus itself.
   function automatic logic [31:0] lane_addr(input logic [31:0] base, input int unsigned idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/sfm_lane_fifo.sv
// Per-lane read-response buffer: synchronous FIFO with soft clear.
// Latency: one cycle from push to visible head/non-empty.
// Backpressure: none on push (caller guarantees no push when full); pop ignored when empty.
module sfm_lane_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; reset and clear both empty the buffer.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage write; data words need no reset since occupancy gates their use.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/sfm_tcdm_splitter.sv
// Splits one wide HCI-style TCDM request into MP 32-bit lane requests and re-joins the read responses.
// Latency: gnt_o combinational on the last lane grant; wide response one cycle after the last lane response.
// Backpressure: reads stall (no lane requests) while FIFO_DEPTH wide reads are unpopped; r_ready_i holds responses.
module sfm_tcdm_splitter
   import sfm_pkg::*;
#(
   parameter int MP         = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic                          req_i,
   output logic                          gnt_o,
   input  logic [31:0]                   add_i,
   input  logic                          wen_i,
   input  logic [MP*TCDM_LANE_BE_W-1:0]  be_i,
   input  logic [MP*TCDM_LANE_W-1:0]     data_i,
   output logic [MP*TCDM_LANE_W-1:0]     r_data_o,
   output logic                          r_valid_o,
   input  logic                          r_ready_i,
   output logic                          busy_o,
   output logic [MP-1:0]                 tcdm_req_o,
   input  logic [MP-1:0]                 tcdm_gnt_i,
   output logic [MP*TCDM_LANE_W-1:0]     tcdm_add_o,
   output logic [MP-1:0]                 tcdm_wen_o,
   output logic [MP*TCDM_LANE_BE_W-1:0]  tcdm_be_o,
   output logic [MP*TCDM_LANE_W-1:0]     tcdm_data_o,
   input  logic [MP*TCDM_LANE_W-1:0]     tcdm_r_data_i,
   input  logic [MP-1:0]                 tcdm_r_valid_i
);

   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   sfm_split_state_e state_q;
   sfm_split_state_e state_d;
   logic [MP-1:0]    granted_q;
   logic [MP-1:0]    granted_d;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   logic             run;
   logic             allow;
   logic             req_active;
   logic             done;
   logic             rd_start;
   logic             pop;
   logic [MP-1:0]    needed;
   logic [MP-1:0]    lane_req;
   logic [MP-1:0]    lane_win;
   logic [MP-1:0]    fifo_full;
   logic [MP-1:0]    fifo_empty;
   logic [31:0]      base_addr;
   logic             unused_bits;

   // Outputs are forced quiet in any cycle where reset or clear is asserted.
   assign run        = rst_ni & ~clear_i;

   // Reads reserve one slot per lane FIFO when they start issuing; once a
   // read has started it must be allowed to finish, hence the PARTIAL term.
   assign allow      = ~wen_i | (state_q == SPLIT_PARTIAL) | (occ_q < OCC_W'(FIFO_DEPTH));
   assign req_active = req_i & allow & run;

   assign base_addr  = {add_i[31:2], 2'b00};

   // Lanes already granted, or not needed by a write, never request again.
   assign lane_req   = {MP{req_active}} & needed & ~granted_q;
   assign lane_win   = lane_req & tcdm_gnt_i;
   assign done       = &(granted_q | lane_win | ~needed);

   assign gnt_o      = req_active & done;
   assign tcdm_req_o = lane_req;
   assign tcdm_wen_o = {MP{wen_i}};
   assign tcdm_be_o  = be_i;
   assign tcdm_data_o = data_i;

   assign r_valid_o  = run & ~(|fifo_empty);
   assign pop        = r_valid_o & r_ready_i;
   assign busy_o     = run & ((state_q == SPLIT_PARTIAL) | (occ_q != '0));

   // Full never coincides with a push: occ_q bounds every lane FIFO's fill.
   // The sub-word address bits are ignored by a word-aligned wide access.
   assign unused_bits = (|fifo_full) | (|add_i[1:0]);

   for (genvar i = 0; i < MP; i++) begin : g_lane
      assign needed[i] = wen_i | (|be_i[i*TCDM_LANE_BE_W +: TCDM_LANE_BE_W]);
      assign tcdm_add_o[i*TCDM_LANE_W +: TCDM_LANE_W] = lane_addr(base_addr, 32'(i));

      sfm_lane_fifo #(
         .WIDTH (TCDM_LANE_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .clear_i   (clear_i),
         .push      (tcdm_r_valid_i[i]),
         .push_data (tcdm_r_data_i[i*TCDM_LANE_W +: TCDM_LANE_W]),
         .pop       (pop),
         .head      (r_data_o[i*TCDM_LANE_W +: TCDM_LANE_W]),
         .full      (fifo_full[i]),
         .empty     (fifo_empty[i])
      );
   end

   // Next-state logic: collect lane grants until every needed lane is covered.
   always_comb begin
      state_d   = state_q;
      granted_d = granted_q;
      rd_start  = 1'b0;
      case (state_q)
         SPLIT_IDLE: begin
            if (req_active) begin
               if (done) begin
                  // Completed in one cycle; a read has granted all lanes here.
                  rd_start = wen_i;
               end else if (|lane_win) begin
                  granted_d = lane_win;
                  state_d   = SPLIT_PARTIAL;
                  rd_start  = wen_i;
               end
            end
         end
         SPLIT_PARTIAL: begin
            if (req_active & done) begin
               granted_d = '0;
               state_d   = SPLIT_IDLE;
            end else begin
               granted_d = granted_q | lane_win;
            end
         end
         default: begin
            state_d   = SPLIT_IDLE;
            granted_d = '0;
         end
      endcase
   end

   // Outstanding wide reads: counted from first lane grant until popped.
   always_comb begin
      occ_d = occ_q;
      case ({rd_start, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers; soft clear abandons any in-flight transaction.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q   <= SPLIT_IDLE;
         granted_q <= '0;
         occ_q     <= '0;
      end else begin
         state_q   <= state_d;
         granted_q <= granted_d;
         occ_q     <= occ_d;
      end
   end

endmodule
